blwl_config_ctrl: RTL
=====================

// Module: blwl_config_ctrl
// PURPOSE
//  Memory-bank configuration controller; sits directly upstream of a grid logic block
//  (grid_x__y_) and drives its bl/wl/prog_EN/prog_ENb pins. Accepts a serial bitstream,
//  assembles one BL row, strobes one WL one-hot, repeats for every WL row, flags config_done.
//  Replaces bench-side rotating-shift BL/WL stimulus with a synthesizable sequencer.
// PARAMETERS
//  NUM_BL       8  number of bit lines (row width, bits per WL row)
//  NUM_WL       4  number of word lines (rows programmed per configuration)
//  PROG_CYCLES  2  clk cycles wl/prog_EN held asserted per row (>=1)
// PORTS
//  clk          in   1          configuration clock, all logic on posedge
//  Reset        in   1          asynchronous, active-high; clears all state
//  start        in   1          1-cycle pulse: begin configuration (honoured in IDLE/DONE only)
//  din          in   1          serial bitstream bit
//  din_valid    in   1          din is valid this cycle
//  din_ready    out  1          controller accepts din this cycle (LOAD state only)
//  bl           out  NUM_BL     bit-line data to grid, bl[0] = first bit received for the row
//  wl           out  NUM_WL     one-hot word-line select, all-zero when not programming
//  prog_EN      out  1          high while a row is being written
//  prog_ENb     out  1          ~prog_EN, always complementary
//  busy         out  1          high in LOAD/PROG/GAP
//  config_done  out  1          high in DONE until next start or Reset
// BEHAVIOUR
//  Reset values: bl=0, wl=0, prog_EN=0, prog_ENb=1, din_ready=0, busy=0, config_done=0;
//   FSM->IDLE, row=0, bit count=0, shift reg=0. Reset mid-operation aborts immediately, no partial write.
//  States: IDLE, LOAD, PROG, GAP, DONE. All outputs registered (no comb. path din->bl/wl).
//  IDLE/DONE --start--> LOAD next cycle; row<=0, bitcnt<=0, config_done<=0.
//  LOAD: din_ready=1. On din_valid&din_ready: shift reg takes din; bitcnt++. din_valid low = stall,
//   no shift, no timeout. Bit k of the row (k=0 first) must land at bl[k].
//  On acceptance of bit NUM_BL-1 -> PROG next cycle; bl<=shift reg on that edge, wl[row]<=1, prog_EN<=1.
//  PROG: bl/wl stable for exactly PROG_CYCLES cycles; din_ready=0; din ignored.
//  GAP: exactly 1 cycle, wl=0, prog_EN=0 (break-before-make); bl keeps last row value.
//   If row==NUM_WL-1 -> DONE, else row++, bitcnt<=0 -> LOAD.
//  DONE: config_done=1, busy=0, bl holds last row, wl=0; stays until start or Reset.
//  start while busy: ignored (no restart, no effect on row/bit counters).
//  wl never has more than one bit set; prog_EN==|wl at all times.
//  Per-row latency with continuous din_valid: NUM_BL + PROG_CYCLES + 1 cycles;
//   total start->config_done = 1 + NUM_WL*(NUM_BL+PROG_CYCLES+1) cycles.
//  Counters sized $clog2 of their range (min 1 bit); row wraps never occur (DONE terminates).
// TESTING (NUM_BL=4, NUM_WL=3, PROG_CYCLES=2)
//  1 Reset asserted async mid-cycle -> all outputs at reset values same instant; prog_ENb=1.
//  2 start, din 1,0,1,1 / 0,1,1,0 / 1,1,1,1 continuous -> bl=1011,wl=100 2 cyc; bl=0110,wl=010;
//    bl=1111,wl=001; config_done=1 exactly 22 cycles after start.
//  3 din_valid low for 5 cycles after 2nd bit of row 0 -> no shift, din_ready stays 1,
//    config_done delayed by exactly 5 cycles, bl values unchanged vs scenario 2.
//  4 start pulsed during PROG of row 1 -> ignored; sequence and config_done timing as scenario 2.
//  5 Reset asserted in PROG of row 1 then released, new start -> restarts at row 0, wl=100 first.
//  6 Check every cycle: prog_ENb==~prog_EN, $onehot0(wl), prog_EN==|wl, GAP cycle wl=0 between rows.

Source files
------------

// File: rtl/blwl_config_if.sv
// Bus between the configuration sequencer and its bitstream source / grid sink.
// master: bitstream source (drives start/din), slave: the controller.
interface blwl_config_if #(
  parameter int NUM_BL = 8,
  parameter int NUM_WL = 4
);
  logic              start;
  logic              din;
  logic              din_valid;
  logic              din_ready;
  logic [NUM_BL-1:0] bl;
  logic [NUM_WL-1:0] wl;
  logic              prog_EN;
  logic              prog_ENb;
  logic              busy;
  logic              config_done;

  modport master (
    output start, din, din_valid,
    input  din_ready, bl, wl, prog_EN, prog_ENb, busy, config_done
  );

  modport slave (
    input  start, din, din_valid,
    output din_ready, bl, wl, prog_EN, prog_ENb, busy, config_done
  );
endinterface

// File: rtl/blwl_config_ctrl.sv
// Memory-bank BL/WL configuration sequencer. Shifts a serial bitstream into a
// row register, writes it on bl while strobing one word line for PROG_CYCLES,
// leaves a one-cycle break-before-make gap, and repeats for all NUM_WL rows.
// Every output is a flop; next values are computed from the next state.
module blwl_config_ctrl #(
  parameter int NUM_BL      = 8,
  parameter int NUM_WL      = 4,
  parameter int PROG_CYCLES = 2
) (
  input  logic         clk,
  input  logic         Reset,
  blwl_config_if.slave bus
);
  localparam int BW = (NUM_BL > 1)      ? $clog2(NUM_BL)      : 1;
  localparam int RW = (NUM_WL > 1)      ? $clog2(NUM_WL)      : 1;
  localparam int PW = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(NUM_BL - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(NUM_WL - 1);
  localparam logic [PW-1:0] PROG_LAST = PW'(PROG_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, PROG, GAP, DONE} state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [BW-1:0]     bitcnt_q, bitcnt_d;
  logic [PW-1:0]     pcnt_q, pcnt_d;
  logic [NUM_BL-1:0] sr_q, sr_d;
  logic [NUM_BL-1:0] bl_q, bl_d;
  logic [NUM_WL-1:0] wl_q, wl_d;
  logic              prog_en_q, prog_en_d;
  logic              prog_enb_q, prog_enb_d;
  logic              din_ready_q, din_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Next-state and next-output logic; outputs follow the state being entered.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    bitcnt_d    = bitcnt_q;
    pcnt_d      = pcnt_q;
    sr_d        = sr_q;
    bl_d        = bl_q;
    wl_d        = wl_q;
    prog_en_d   = prog_en_q;
    din_ready_d = din_ready_q;
    busy_d      = busy_q;
    done_d      = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = LOAD;
          row_d       = '0;
          bitcnt_d    = '0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          din_ready_d = 1'b1;
        end
      end
      LOAD: begin
        if (bus.din_valid && din_ready_q) begin
          // Shift toward bit 0 so the first bit received ends up at bl[0].
          sr_d             = sr_q >> 1;
          sr_d[NUM_BL-1]   = bus.din;
          bitcnt_d         = bitcnt_q + 1'b1;
          if (bitcnt_q == BIT_LAST) begin
            state_d     = PROG;
            bl_d        = sr_d;
            wl_d        = NUM_WL'(1) << row_q;
            prog_en_d   = 1'b1;
            pcnt_d      = '0;
            din_ready_d = 1'b0;
          end
        end
      end
      PROG: begin
        if (pcnt_q == PROG_LAST) begin
          state_d   = GAP;
          wl_d      = '0;
          prog_en_d = 1'b0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      GAP: begin
        if (row_q == ROW_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d     = LOAD;
          row_d       = row_q + 1'b1;
          bitcnt_d    = '0;
          din_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        wl_d        = '0;
        prog_en_d   = 1'b0;
        din_ready_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
    prog_enb_d = ~prog_en_d;
  end

  // Single state/output register; reset aborts any write in progress.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      bitcnt_q    <= '0;
      pcnt_q      <= '0;
      sr_q        <= '0;
      bl_q        <= '0;
      wl_q        <= '0;
      prog_en_q   <= 1'b0;
      prog_enb_q  <= 1'b1;
      din_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      bitcnt_q    <= bitcnt_d;
      pcnt_q      <= pcnt_d;
      sr_q        <= sr_d;
      bl_q        <= bl_d;
      wl_q        <= wl_d;
      prog_en_q   <= prog_en_d;
      prog_enb_q  <= prog_enb_d;
      din_ready_q <= din_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.bl          = bl_q;
  assign bus.wl          = wl_q;
  assign bus.prog_EN     = prog_en_q;
  assign bus.prog_ENb    = prog_enb_q;
  assign bus.din_ready   = din_ready_q;
  assign bus.busy        = busy_q;
  assign bus.config_done = done_q;
endmodule
